issue_queue_param: RTL

Parametrised, age-ordered issue queue (reservation station) that sits between the dispatch stage and one execution unit (ALU, SFU, BRU or AGU). It accepts up to DW renamed instructions per cycle and tracks readiness of two physical source registers per entry. Readiness is updated from WAKE_N result-tag broadcast ports. Each cycle it issues the oldest entry whose sources are both ready. Unlike the fixed per-unit stations, depth, dispatch width, payload width, tag width and wakeup-port count are all parameters, and the block adds same-cycle dispatch wakeup and a full recover flush.

---
 rtl/issue_queue_param.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/issue_queue_param.sv
// Parametrised age-ordered issue queue (compacting, oldest at index 0).
// Tracks two source ready bits per entry and issues the oldest ready one.
module issue_queue_param #(
  parameter int DEPTH     = 8,
  parameter int DW        = 2,
  parameter int PAYLOAD_W = 64,
  parameter int TAG_W     = 6,
  parameter int WAKE_N    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         recover,
  input  logic [DW-1:0]                disp_valid,
  output logic                         disp_ready,
  input  logic [DW*TAG_W-1:0]          disp_src1_tag,
  input  logic [DW*TAG_W-1:0]          disp_src2_tag,
  input  logic [DW-1:0]                disp_src1_rdy,
  input  logic [DW-1:0]                disp_src2_rdy,
  input  logic [DW*PAYLOAD_W-1:0]      disp_payload,
  input  logic [WAKE_N-1:0]            wake_valid,
  input  logic [WAKE_N*TAG_W-1:0]      wake_tag,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [PAYLOAD_W-1:0]         iss_payload,
  output logic [TAG_W-1:0]             iss_src1_tag,
  output logic [TAG_W-1:0]             iss_src2_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic                 vld [DEPTH];
  logic [TAG_W-1:0]     t1  [DEPTH];
  logic                 r1  [DEPTH];
  logic [TAG_W-1:0]     t2  [DEPTH];
  logic                 r2  [DEPTH];
  logic [PAYLOAD_W-1:0] pl  [DEPTH];

  logic                 n_vld [DEPTH];
  logic [TAG_W-1:0]     n_t1  [DEPTH];
  logic                 n_r1  [DEPTH];
  logic [TAG_W-1:0]     n_t2  [DEPTH];
  logic                 n_r2  [DEPTH];
  logic [PAYLOAD_W-1:0] n_pl  [DEPTH];

  logic found;
  logic do_iss;
  int   sel;
  int   base;
  int   acc_n;
  int   n_cnt;

  function automatic logic woken(
    input logic [TAG_W-1:0]        t,
    input logic [WAKE_N-1:0]       wv,
    input logic [WAKE_N*TAG_W-1:0] wt
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_N; k++)
      if (wv[k] && wt[k*TAG_W +: TAG_W] == t)
        hit = 1'b1;
    return hit;
  endfunction

  assign disp_ready = (DEPTH - int'(count)) >= DW;
  assign do_iss     = found && iss_ready;
  assign iss_valid  = found;

  // Select: lowest-index valid entry with both sources ready.
  always_comb begin
    found = 1'b0;
    sel   = 0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (vld[i] && r1[i] && r2[i]) begin
        found = 1'b1;
        sel   = i;
      end
  end

  // Issue mux; falls back to index 0 when nothing is ready.
  always_comb begin
    iss_payload  = pl[0];
    iss_src1_tag = t1[0];
    iss_src2_tag = t2[0];
    for (int i = 1; i < DEPTH; i++)
      if (found && sel == i) begin
        iss_payload  = pl[i];
        iss_src1_tag = t1[i];
        iss_src2_tag = t2[i];
      end
  end

  // Next state: remove issued entry, shift, append, then wakeup-merge.
  always_comb begin
    base  = int'(count) - (do_iss ? 1 : 0);
    acc_n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      n_vld[i] = vld[i];
      n_t1[i]  = t1[i];
      n_r1[i]  = r1[i];
      n_t2[i]  = t2[i];
      n_r2[i]  = r2[i];
      n_pl[i]  = pl[i];
    end
    if (do_iss) begin
      for (int i = 0; i < DEPTH-1; i++)
        if (i >= sel) begin
          n_vld[i] = vld[i+1];
          n_t1[i]  = t1[i+1];
          n_r1[i]  = r1[i+1];
          n_t2[i]  = t2[i+1];
          n_r2[i]  = r2[i+1];
          n_pl[i]  = pl[i+1];
        end
      n_vld[DEPTH-1] = 1'b0;
    end
    if (disp_ready)
      for (int p = 0; p < DW; p++)
        if (disp_valid[p]) begin
          for (int j = 0; j < DEPTH; j++)
            if (j == base + acc_n) begin
              n_vld[j] = 1'b1;
              n_t1[j]  = disp_src1_tag[p*TAG_W +: TAG_W];
              n_r1[j]  = disp_src1_rdy[p];
              n_t2[j]  = disp_src2_tag[p*TAG_W +: TAG_W];
              n_r2[j]  = disp_src2_rdy[p];
              n_pl[j]  = disp_payload[p*PAYLOAD_W +: PAYLOAD_W];
            end
          acc_n = acc_n + 1;
        end
    for (int j = 0; j < DEPTH; j++) begin
      if (woken(n_t1[j], wake_valid, wake_tag))
        n_r1[j] = 1'b1;
      if (woken(n_t2[j], wake_valid, wake_tag))
        n_r2[j] = 1'b1;
    end
    n_cnt = base + acc_n;
  end

  // State register; rst wipes storage, recover only drops valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld[i] <= 1'b0;
        t1[i]  <= '0;
        r1[i]  <= 1'b0;
        t2[i]  <= '0;
        r2[i]  <= 1'b0;
        pl[i]  <= '0;
      end
      count <= '0;
    end else if (recover) begin
      for (int i = 0; i < DEPTH; i++)
        vld[i] <= 1'b0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vld[i] <= n_vld[i];
        t1[i]  <= n_t1[i];
        r1[i]  <= n_r1[i];
        t2[i]  <= n_t2[i];
        r2[i]  <= n_r2[i];
        pl[i]  <= n_pl[i];
      end
      count <= CW'(n_cnt);
    end
  end

endmodule
